// File: rtl/axi_pkg.sv
// Shared AXI-lite definitions for the fetch and data responders:
// response codes, the responder FSM states and the default pmem window.
package axi_pkg;

    localparam logic RESP_OKAY = 1'b0;
    localparam logic RESP_ERR  = 1'b1;

    // pmem map used by the core; responders default to this window
    localparam logic [31:0] PMEM_BASE = 32'h8000_0000;
    localparam logic [31:0] PMEM_SIZE = 32'h0800_0000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        READ,
        RESP
    } rsp_state_e;

endpackage

// File: rtl/axi_ifetch_responder_if.sv
// AR/R channel bundle between the fetch initiator and the responder.
interface axi_ifetch_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              araddr_valid;
    logic              araddr_ready;
    logic [ADDR_W-1:0] araddr_bits_addr;
    logic              raddr_valid;
    logic              raddr_ready;
    logic [DATA_W-1:0] raddr_bits_data;
    logic              raddr_bits_resp;

    modport master (
        output araddr_valid, araddr_bits_addr, raddr_ready,
        input  araddr_ready, raddr_valid, raddr_bits_data, raddr_bits_resp
    );

    modport slave (
        input  araddr_valid, araddr_bits_addr, raddr_ready,
        output araddr_ready, raddr_valid, raddr_bits_data, raddr_bits_resp
    );
endinterface

// File: rtl/ifetch_addr_check.sv
// Combinational window and alignment check for a word access; also
// produces the word index relative to BASE.
module ifetch_addr_check #(
    parameter int                ADDR_W = 32,
    parameter int                MEM_AW = 25,
    parameter logic [ADDR_W-1:0] BASE   = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] SIZE   = 32'h0800_0000
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              err,
    output logic [MEM_AW-1:0] idx
);
    // one extra bit so BASE + SIZE at the top of the address space cannot wrap
    logic [ADDR_W:0] a_ext, lo, hi;

    assign a_ext = {1'b0, addr};
    assign lo    = {1'b0, BASE};
    assign hi    = {1'b0, BASE} + {1'b0, SIZE};
    assign err   = (addr[1:0] != 2'b00) || (a_ext < lo) || (a_ext >= hi);
    assign idx   = MEM_AW'((addr - BASE) >> 2);
endmodule

// File: rtl/axi_ifetch_responder.sv
// Single-outstanding AXI-lite read responder for instruction fetch.
// Accepts one address, waits LATENCY cycles, reads one SRAM word and
// returns it on R; out-of-window or misaligned requests answer ERROR
// without touching the SRAM.
module axi_ifetch_responder
    import axi_pkg::*;
#(
    parameter int                ADDR_W  = 32,
    parameter int                DATA_W  = 32,
    parameter logic [ADDR_W-1:0] BASE    = PMEM_BASE,
    parameter logic [ADDR_W-1:0] SIZE    = PMEM_SIZE,
    parameter int                LATENCY = 2,
    parameter int                MEM_AW  = 25
) (
    input  logic                  clk,
    input  logic                  rst,
    axi_ifetch_responder_if.slave io_AXI,
    output logic                  mem_ren,
    output logic [MEM_AW-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [31:0]           resp_cnt
);
    rsp_state_e        state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic              arready_q;
    logic              ar_hs;
    logic              chk_err;
    logic [MEM_AW-1:0] chk_idx;
    logic [MEM_AW-1:0] mem_addr_q;
    logic [DATA_W-1:0] rdata_q;
    logic              resp_q;
    logic              cap_q;
    logic [31:0]       resp_cnt_q;

    ifetch_addr_check #(
        .ADDR_W(ADDR_W), .MEM_AW(MEM_AW), .BASE(BASE), .SIZE(SIZE)
    ) u_chk (
        .addr(io_AXI.araddr_bits_addr),
        .err (chk_err),
        .idx (chk_idx)
    );

    assign ar_hs = io_AXI.araddr_valid && arready_q;

    // next-state and wait counter
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: if (ar_hs) begin
                if (chk_err)           state_nx = RESP;
                else if (LATENCY == 0) state_nx = READ;
                else begin
                    state_nx = WAIT;
                    cnt_nx   = 4'(LATENCY - 1);
                end
            end
            WAIT: if (cnt == 4'd0) state_nx = READ;
                  else             cnt_nx   = cnt - 4'd1;
            READ: state_nx = RESP;
            RESP: if (io_AXI.raddr_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // state, counter and registered arready (high exactly while IDLE)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            arready_q <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            arready_q <= (state_nx == IDLE);
        end
    end

    // request latch, response capture and completion counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr_q <= '0;
            rdata_q    <= '0;
            resp_q     <= RESP_OKAY;
            cap_q      <= 1'b0;
            resp_cnt_q <= '0;
        end else begin
            cap_q <= (state == READ);
            if (ar_hs) begin
                if (chk_err) begin
                    rdata_q <= '0;
                    resp_q  <= RESP_ERR;
                end else begin
                    mem_addr_q <= chk_idx;
                end
            end
            if (state == READ) resp_q  <= RESP_OKAY;
            if (cap_q)         rdata_q <= mem_rdata;
            if (state == RESP && io_AXI.raddr_ready) resp_cnt_q <= resp_cnt_q + 32'd1;
        end
    end

    // SRAM data arrives in the first RESP cycle: forward it then, and
    // present the captured copy for the rest of the beat
    always_comb begin
        io_AXI.raddr_bits_data = cap_q ? mem_rdata : rdata_q;
    end

    assign io_AXI.araddr_ready    = arready_q;
    assign io_AXI.raddr_valid     = (state == RESP);
    assign io_AXI.raddr_bits_resp = resp_q;
    assign mem_ren                = (state == READ);
    assign mem_addr               = mem_addr_q;
    assign resp_cnt               = resp_cnt_q;
endmodule

// File: tb/tb_axi_ifetch_responder.sv
// Scoreboard bench: one responder at LATENCY=2 for directed/random/reset
// tests, one at LATENCY=0 for back-to-back fetches.
module tb_axi_ifetch_responder;
    localparam int          AW = 32, DW = 32, MAW = 25;
    localparam logic [31:0] BASE = 32'h8000_0000, SIZE = 32'h0800_0000;
    localparam int          LAT = 2;

    logic clk = 1'b0, rst = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    axi_ifetch_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();
    axi_ifetch_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
    logic           mem_ren2, mem_ren0;
    logic [MAW-1:0] mem_addr2, mem_addr0;
    logic [DW-1:0]  mem_rdata2 = '0, mem_rdata0 = '0;
    logic [31:0]    cnt2, cnt0;

    axi_ifetch_responder #(.LATENCY(LAT)) u2 (
        .clk(clk), .rst(rst), .io_AXI(bus2), .mem_ren(mem_ren2),
        .mem_addr(mem_addr2), .mem_rdata(mem_rdata2), .resp_cnt(cnt2));
    axi_ifetch_responder #(.LATENCY(0)) u0 (
        .clk(clk), .rst(rst), .io_AXI(bus0), .mem_ren(mem_ren0),
        .mem_addr(mem_addr0), .mem_rdata(mem_rdata0), .resp_cnt(cnt0));

    // instruction memory contents: word 0 is fixed, the rest a hash of the index
    function automatic logic [31:0] memf(input logic [MAW-1:0] i);
        logic [31:0] w;
        w = {7'd0, i};
        return (i == '0) ? 32'h0010_0073 : ((w * 32'h9E37_79B1) ^ 32'hA5A5_0F0F);
    endfunction

    // synchronous SRAM models
    always @(posedge clk) begin
        if (mem_ren2) mem_rdata2 <= memf(mem_addr2);
        if (mem_ren0) mem_rdata0 <= memf(mem_addr0);
    end

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask
    task automatic tmo(input string nm);
        n_chk++; n_fail++;
        $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
    endtask

    // reference model
    function automatic bit is_err(input logic [31:0] a);
        longint la, lb, ls;
        la = longint'({32'd0, a}); lb = longint'({32'd0, BASE}); ls = longint'({32'd0, SIZE});
        return (a % 4 != 0) || (la < lb) || (la >= lb + ls);
    endfunction
    function automatic logic [MAW-1:0] word_of(input logic [31:0] a);
        return MAW'((a - BASE) / 4);
    endfunction

    typedef struct { logic [31:0] data; logic resp; int due; } exp_t;
    typedef struct { logic [MAW-1:0] idx; int due; } mexp_t;
    exp_t  rq[$];
    mexp_t mq[$];
    exp_t  cur;
    int    exp_cnt = 0;
    bit    pend = 0, rv_prev = 0;

    task automatic push_req(input logic [31:0] a);
        exp_t e; mexp_t m;
        e.resp = is_err(a);
        e.data = e.resp ? 32'd0 : memf(word_of(a));
        e.due  = cyc + (e.resp ? 1 : LAT + 2);
        rq.push_back(e);
        if (!e.resp) begin
            m.idx = word_of(a); m.due = cyc + LAT + 1;
            mq.push_back(m);
        end
    endtask

    task automatic flush();
        rq.delete(); mq.delete(); exp_cnt = 0; pend = 0;
    endtask

    // monitor for the LATENCY=2 responder
    always @(negedge clk) begin
        if (!rst) begin
            rv_prev = 0; pend = 0;
        end else begin
            if (pend) begin
                chk("resp_cnt", cnt2, exp_cnt);
                chk("arready_back", bus2.araddr_ready, 1);
                pend = 0;
            end
            if (bus2.raddr_valid && !rv_prev) begin
                if (rq.size() == 0) tmo("unexpected_rvalid");
                else begin
                    cur = rq.pop_front();
                    chk("rvalid_cycle", cyc, cur.due);
                end
            end
            if (bus2.raddr_valid) begin
                chk("rdata", bus2.raddr_bits_data, cur.data);
                chk("resp", bus2.raddr_bits_resp, cur.resp);
                chk("arready_busy", bus2.araddr_ready, 0);
                if (bus2.raddr_ready) begin exp_cnt++; pend = 1; end
            end
            if (mem_ren2) begin
                if (mq.size() == 0) tmo("unexpected_mem_ren");
                else begin
                    mexp_t m;
                    m = mq.pop_front();
                    chk("mem_addr", mem_addr2, m.idx);
                    chk("mem_ren_cycle", cyc, m.due);
                end
            end
            rv_prev = bus2.raddr_valid;
        end
    end

    // monitor for the LATENCY=0 responder
    int          t0q[$];
    logic [31:0] d0q[$];
    always @(negedge clk) begin
        if (rst) begin
            if (bus0.araddr_valid && bus0.araddr_ready) begin
                t0q.push_back(cyc);
                d0q.push_back(memf(word_of(bus0.araddr_bits_addr)));
            end
            if (bus0.raddr_valid) begin
                if (t0q.size() == 0) tmo("l0_unexpected_rvalid");
                else begin
                    chk("l0_latency", cyc - t0q.pop_front(), 2);
                    chk("l0_rdata", bus0.raddr_bits_data, d0q.pop_front());
                    chk("l0_resp", bus0.raddr_bits_resp, 0);
                end
            end
        end
    end

    // issue one AR on bus2 and wait for its handshake; returns 0 on timeout
    task automatic issue(input logic [31:0] a, input bit rr, output bit ok);
        int t;
        @(posedge clk); #1;
        bus2.araddr_valid = 1; bus2.araddr_bits_addr = a; bus2.raddr_ready = rr;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus2.araddr_ready && t < 50);
        ok = bus2.araddr_ready;
        if (ok) push_req(a); else tmo("ar_handshake");
        @(posedge clk); #1 bus2.araddr_valid = 0;
    endtask

    task automatic wait_rvalid(output bit ok);
        int t;
        t = 0;
        while (!bus2.raddr_valid && t < 50) begin @(negedge clk); t++; end
        ok = bus2.raddr_valid;
        if (!ok) tmo("rvalid_wait");
    endtask

    // full request; hold = cycles rready stays low once rvalid is up
    task automatic do_req(input logic [31:0] a, input int hold);
        bit ok;
        int t;
        issue(a, hold == 0, ok);
        if (!ok) return;
        wait_rvalid(ok);
        if (!ok) return;
        if (hold > 0) begin
            repeat (hold - 1) @(negedge clk);
            @(posedge clk); #1 bus2.raddr_ready = 1;
        end
        t = 0;
        while (!(bus2.raddr_valid && bus2.raddr_ready) && t < 50) begin @(negedge clk); t++; end
        @(posedge clk); #1 bus2.raddr_ready = 0;
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_arready"}, bus2.araddr_ready, 0);
        chk({tag, "_rvalid"}, bus2.raddr_valid, 0);
        chk({tag, "_rdata"}, bus2.raddr_bits_data, 0);
        chk({tag, "_resp"}, bus2.raddr_bits_resp, 0);
        chk({tag, "_mem_ren"}, mem_ren2, 0);
        chk({tag, "_mem_addr"}, mem_addr2, 0);
        chk({tag, "_resp_cnt"}, cnt2, 0);
    endtask

    task automatic release_rst(input string tag);
        @(negedge clk); #1 rst = 1;
        chk({tag, "_arready_pre_edge"}, bus2.araddr_ready, 0);
        @(posedge clk); #1;
        chk({tag, "_arready_first_edge"}, bus2.araddr_ready, 1);
        chk({tag, "_resp_cnt_rel"}, cnt2, 0);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] ok_a;
        ok_a = BASE + ($urandom_range(0, 32'h01FF_FFFF) << 2);
        case ($urandom_range(0, 5))
            0, 1, 2: return ok_a;
            3:       return ok_a | $urandom_range(1, 3);
            4:       return BASE - 4 * $urandom_range(1, 1000);
            default: return BASE + SIZE + 4 * $urandom_range(0, 1000);
        endcase
    endfunction

    initial begin
        bit ok;
        bus2.araddr_valid = 0; bus2.araddr_bits_addr = '0; bus2.raddr_ready = 0;
        bus0.araddr_valid = 0; bus0.araddr_bits_addr = '0; bus0.raddr_ready = 0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        release_rst("init");

        // directed window edges, misalignment and backpressure
        do_req(32'h8000_0000, 0);
        do_req(32'h8000_0002, 0);
        do_req(32'h7FFF_FFFC, 1);
        do_req(32'h8800_0000, 0);
        do_req(32'h87FF_FFFC, 0);
        do_req(32'hFFFF_FFFC, 0);
        do_req(32'h8000_0010, 5);
        do_req(32'h8000_0001, 3);

        // random mix
        for (int i = 0; i < 40; i++) do_req(rand_addr(), $urandom_range(0, 3));

        // reset during WAIT
        issue(32'h8000_0040, 0, ok);
        #2 rst = 0;
        #1 check_zero("rst_wait");
        flush();
        release_rst("wait");
        do_req(32'h8000_0044, 0);

        // reset during RESP, with a nonzero word on the bus
        issue(32'h8000_0048, 0, ok);
        wait_rvalid(ok);
        @(posedge clk); #2;
        chk("pre_rst_rvalid", bus2.raddr_valid, 1);
        rst = 0;
        #1 check_zero("rst_resp");
        flush();
        release_rst("resp");
        do_req(32'h8000_004C, 2);

        // LATENCY=0 back-to-back with arvalid held high
        bus0.raddr_ready = 1;
        @(posedge clk); #1;
        bus0.araddr_valid = 1;
        bus0.araddr_bits_addr = BASE + ($urandom_range(0, 32'h01FF_FFFF) << 2);
        for (int i = 0; i < 8; i++) begin
            int t;
            t = 0;
            do begin @(negedge clk); t++; end while (!bus0.araddr_ready && t < 50);
            if (!bus0.araddr_ready) begin tmo("l0_ar_handshake"); break; end
            @(posedge clk); #1;
            bus0.araddr_bits_addr = BASE + ($urandom_range(0, 32'h01FF_FFFF) << 2);
            if (i == 7) bus0.araddr_valid = 0;
        end
        repeat (5) @(negedge clk);
        chk("l0_resp_cnt", cnt0, 8);
        chk("l0_sb_empty", t0q.size(), 0);
        chk("sb_empty", rq.size(), 0);
        chk("mem_sb_empty", mq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation bound reached");
        $fatal(1);
    end
endmodule
